// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared widths and FSM state type for the data-memory arbiter.
package dm_arb_pkg;
   localparam int unsigned DM_DW = 30;
   localparam int unsigned DM_AW = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } dm_state_t;
endpackage

// File: rtl/dm_arb_pick.sv
// dm_arb_pick: grant decision between the two requesters.
// DM_ARB_ROUND_ROBIN_EN selects round-robin on conflict; otherwise requester 0 wins.
module dm_arb_pick (
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic winner
);
`ifdef DM_ARB_ROUND_ROBIN_EN
   // on conflict grant the requester that was not granted last
   always_comb begin
      winner = 1'b0;
      if (req0 && req1) winner = ~last;
      else              winner = req1;
   end
`else
   // the pointer has no meaning under fixed priority
   logic w_unused_last;
   assign w_unused_last = last;

   // fixed priority: requester 0 always wins
   always_comb begin
      winner = 1'b0;
      if (!req0 && req1) winner = 1'b1;
   end
`endif
endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-requester arbiter in front of a single-port data memory.
// One access per IDLE -> ACC -> DONE pass; DM_ARB_ROUND_ROBIN_EN enables
// round-robin conflict resolution (default build: fixed priority to port 0).
module dm_arbiter
   import dm_arb_pkg::*;
#(
   parameter int unsigned DW = DM_DW,
   parameter int unsigned AW = DM_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          ack0,
   output logic          ack1,
   output logic [DW-1:0] rdata0,
   output logic [DW-1:0] rdata1,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);
   dm_state_t     r_state;
   dm_state_t     w_next;
   logic          r_win;
   logic          r_we;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata;
   logic [DW-1:0] r_rdata0;
   logic [DW-1:0] r_rdata1;
   logic          w_last;
   logic          w_winner;
   logic          w_grant;

   assign w_grant = (r_state == IDLE) && (req0 || req1);

`ifdef DM_ARB_ROUND_ROBIN_EN
   logic r_last;

   // last-grant pointer, updated on every grant
   always_ff @(posedge clk) begin
      if (rst)          r_last <= 1'b1;
      else if (w_grant) r_last <= w_winner;
   end
   assign w_last = r_last;
`else
   assign w_last = 1'b1;
`endif

   dm_arb_pick u_pick (
      .req0   (req0),
      .req1   (req1),
      .last   (w_last),
      .winner (w_winner)
   );

   // state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // next state and per-state outputs
   always_comb begin
      w_next = r_state;
      ack0   = 1'b0;
      ack1   = 1'b0;
      mem_we = 1'b0;
      busy   = 1'b1;
      case (r_state)
         IDLE: begin
            busy = 1'b0;
            if (w_grant) w_next = ACC;
         end
         ACC: begin
            // gating with rst keeps an aborted write out of the memory
            mem_we = r_we & ~rst;
            w_next = DONE;
         end
         DONE: begin
            ack0   = ~r_win;
            ack1   = r_win;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // latch the winner's transaction when it is granted
   always_ff @(posedge clk) begin
      if (rst) begin
         r_win   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (w_grant) begin
         r_win   <= w_winner;
         r_we    <= w_winner ? we1 : we0;
         r_addr  <= w_winner ? addr1 : addr0;
         r_wdata <= w_winner ? wdata1 : wdata0;
      end
   end

   // capture read data into the winner's register at the end of ACC
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata0 <= '0;
         r_rdata1 <= '0;
      end else if (r_state == ACC && !r_we) begin
         if (r_win) r_rdata1 <= mem_rdata;
         else       r_rdata0 <= mem_rdata;
      end
   end

   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign rdata0    = r_rdata0;
   assign rdata1    = r_rdata1;
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: scoreboard bench for dm_arbiter with a behavioural memory.
// Honours DM_ARB_ROUND_ROBIN_EN for the expected conflict grant order.
module tb_dm_arbiter;
   localparam int AW = 10;
   localparam int DW = 30;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0, req1, we0, we1;
   logic [AW-1:0] addr0, addr1, mem_addr;
   logic [DW-1:0] wdata0, wdata1, rdata0, rdata1, mem_wdata, mem_rdata;
   logic          ack0, ack1, mem_we, busy;

   dm_arbiter #(.DW(DW), .AW(AW)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   // memory attached to the arbiter, and the bench's own view of its contents
   logic [DW-1:0] mem    [0:(1<<AW)-1];
   logic [DW-1:0] shadow [0:(1<<AW)-1];
   always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
   assign mem_rdata = mem[mem_addr];

   int            checks = 0;
   int            errors = 0;
   bit            sb_en  = 1'b0;
   logic [DW-1:0] q0[$];
   logic [DW-1:0] q1[$];
   logic [DW-1:0] cur0, cur1, iss0, iss1, e0, e1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // monitor: pops the expected read data whenever an ack appears
   always @(negedge clk) begin
      if (!rst) chk("ack_exclusive", 64'(ack0 & ack1), 64'(0));
      if (mem_we) chk("busy_on_we", 64'(busy), 64'(1));
      if (sb_en && ack0) begin
         if (q0.size() == 0) chk("ack0_unexpected", 64'(ack0), 64'(0));
         else begin
            e0 = q0.pop_front();
            chk("rdata0", 64'(rdata0), 64'(e0));
            cur0 = e0;
            chk("rdata1_hold", 64'(rdata1), 64'(cur1));
         end
      end
      if (sb_en && ack1) begin
         if (q1.size() == 0) chk("ack1_unexpected", 64'(ack1), 64'(0));
         else begin
            e1 = q1.pop_front();
            chk("rdata1", 64'(rdata1), 64'(e1));
            cur1 = e1;
            chk("rdata0_hold", 64'(rdata0), 64'(cur0));
         end
      end
   end

   task automatic clear_model();
      q0.delete();
      q1.delete();
      cur0 = '0; cur1 = '0; iss0 = '0; iss1 = '0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_ack0", 64'(ack0), 64'(0));
      chk("rst_ack1", 64'(ack1), 64'(0));
      chk("rst_mem_we", 64'(mem_we), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_mem_addr", 64'(mem_addr), 64'(0));
      chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
      chk("rst_rdata0", 64'(rdata0), 64'(0));
      chk("rst_rdata1", 64'(rdata1), 64'(0));
      clear_model();
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // one transaction on port p; solo means no competing traffic, so exact timing is known
   task automatic do_txn(input bit p, input bit w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input bit solo);
      logic [DW-1:0] exp;
      int            n;
      bit            got;
      @(posedge clk); #1;
      if (w) begin
         shadow[a] = d;
         exp = p ? iss1 : iss0;
      end else begin
         exp = shadow[a];
         if (p) iss1 = exp; else iss0 = exp;
      end
      if (p) begin
         q1.push_back(exp);
         req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
      end else begin
         q0.push_back(exp);
         req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
      end
      n = 0;
      got = 1'b0;
      while (!got && n < 60) begin
         @(negedge clk);
         n++;
         got = p ? ack1 : ack0;
         if (solo) begin
            if (n == 2) begin
               chk("acc_we", 64'(mem_we), 64'(w));
               chk("acc_addr", 64'(mem_addr), 64'(a));
               if (w) chk("acc_wdata", 64'(mem_wdata), 64'(d));
            end else begin
               chk("non_acc_we", 64'(mem_we), 64'(0));
            end
         end
      end
      chk("ack_seen", 64'(got), 64'(1));
      if (solo) chk("latency", 64'(n), 64'(3));
      @(posedge clk); #1;
      if (p) req1 = 1'b0; else req0 = 1'b0;
   endtask

   task automatic rand_port(input bit p, input int cnt);
      bit            w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      for (int i = 0; i < cnt; i++) begin
         repeat ($urandom_range(0, 2)) @(posedge clk);
         w = 1'($urandom_range(0, 1));
         a = (p ? 10'h200 : 10'h000) + 10'($urandom_range(0, 15));
         d = 30'($urandom());
         do_txn(p, w, a, d, 1'b0);
      end
   endtask

   // both requesters held high; expected grant order from the arbitration rule
   task automatic conflict_test();
      bit last_g;
      bit g;
      int k;
      last_g = 1'b1;
      g = 1'b0;
      @(posedge clk); #1;
      req0 = 1'b1; we0 = 1'b0; addr0 = 10'h005;
      req1 = 1'b1; we1 = 1'b0; addr1 = 10'h205;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         k = i / 3;
         if (i % 3 == 0) begin
`ifdef DM_ARB_ROUND_ROBIN_EN
            g = ~last_g;
`else
            g = 1'b0;
`endif
            last_g = g;
            chk($sformatf("conf_ack0_g%0d", k), 64'(ack0), 64'(!g));
            chk($sformatf("conf_ack1_g%0d", k), 64'(ack1), 64'(g));
         end else begin
            chk("conf_ack0_gap", 64'(ack0), 64'(0));
            chk("conf_ack1_gap", 64'(ack1), 64'(0));
         end
      end
`ifdef DM_ARB_ROUND_ROBIN_EN
      @(posedge clk); #1;
      req0 = 1'b0; req1 = 1'b0;
`else
      @(posedge clk); #1;
      req0 = 1'b0;
      for (int j = 1; j <= 3; j++) begin
         @(negedge clk);
         chk("fix_ack0_after_drop", 64'(ack0), 64'(0));
         chk($sformatf("fix_ack1_c%0d", j), 64'(ack1), 64'(j == 3));
      end
      @(posedge clk); #1;
      req1 = 1'b0;
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      for (int i = 0; i < (1 << AW); i++) begin
         mem[i]    = '0;
         shadow[i] = '0;
      end
      rst = 1'b1;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      clear_model();
      do_reset();
      sb_en = 1'b1;

      // idle: nothing requested, nothing moves
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_outputs", 64'({mem_we, ack0, ack1, busy}), 64'(0));
      end

      // single write then read-back on port 0
      do_txn(1'b0, 1'b1, 10'h2AA, 30'h3FFFFFFF, 1'b1);
      do_txn(1'b0, 1'b0, 10'h2AA, 30'h0, 1'b1);

      // conflict behaviour from a fresh reset
      do_reset();
      sb_en = 1'b0;
      conflict_test();
      do_reset();
      sb_en = 1'b1;

      // reset sampled at the ACC edge aborts a port-1 write
      do_txn(1'b1, 1'b1, 10'h248, 30'h0000_1234, 1'b1);
      @(posedge clk); #1;
      req1 = 1'b1; we1 = 1'b1; addr1 = 10'h248; wdata1 = 30'h2FFFFFFF;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("abort_mem_we", 64'(mem_we), 64'(0));
      @(posedge clk); #1;
      rst = 1'b0; req1 = 1'b0; we1 = 1'b0;
      clear_model();
      @(negedge clk);
      chk("abort_busy", 64'(busy), 64'(0));
      chk("abort_ack1", 64'(ack1), 64'(0));
      chk("abort_mem", 64'(mem[10'h248]), 64'(30'h0000_1234));
      do_txn(1'b1, 1'b0, 10'h248, 30'h0, 1'b1);

      // concurrent random traffic on both ports
      fork
         rand_port(1'b0, 30);
         rand_port(1'b1, 30);
      join
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("q0_drained", 64'(q0.size()), 64'(0));
      chk("q1_drained", 64'(q1.size()), 64'(0));
      chk("final_busy", 64'(busy), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have parameter DW, default 30, data word width matching the data memory.
REQ-002 SHALL have parameter AW, default 10, word address width matching the data memory.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports req0/req1  input  1  access request from requester 0 (CPU) and requester 1 (debug/DMA).
REQ-006 SHALL have ports we0/we1  input  1  1 = write, 0 = read.
REQ-007 SHALL have ports addr0/addr1  input  AW  word address.
REQ-008 SHALL have ports wdata0/wdata1  input  DW  write data.
REQ-009 SHALL have ports ack0/ack1  output  1  one-cycle completion pulse.
REQ-010 SHALL have ports rdata0/rdata1  output  DW  registered read data.
REQ-011 SHALL have ports mem_addr (output, AW), mem_wdata (output, DW), mem_we (output, 1) and mem_rdata (input, DW), connecting to the memory's addr, datain, memwr and dataout.
REQ-012 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 SHALL implement FSM IDLE -> ACC -> DONE -> IDLE.
REQ-014 IDLE: sample req0/req1; if either is high, latch the winner's index, we, addr and wdata, then go to ACC; otherwise stay in IDLE.
REQ-015 ACC (exactly one cycle): drive latched mem_addr and mem_wdata; mem_we = latched we; capture mem_rdata into the winner's rdata register at the closing edge (read only).
REQ-016 DONE: assert the winner's ack for exactly one cycle, keep mem_we=0, then return to IDLE.
REQ-017 Latency: request sampled at edge N; memory access during cycle N+1; ack high during cycle N+2; next grant is possible at edge N+3.
REQ-018 Outside ACC, mem_we SHALL be 0; mem_addr and mem_wdata SHALL hold their last latched values.
REQ-019 The requester SHALL hold req, we, addr and wdata stable until its ack and drop req in the cycle after ack; req still high in IDLE is a new request.
REQ-020 rdataX SHALL hold its value until the next read completes on port X; writes SHALL not alter it.
REQ-021 Simultaneous requests SHALL be resolved per REQ-027/028; the loser's request stays pending and is not lost.
REQ-022 The loser's ack SHALL never assert during the winner's transaction; ack0 and ack1 SHALL never be high together.

Reset
REQ-023 While rst is high at an edge: state=IDLE, ack0=ack1=0, mem_we=0, busy=0, mem_addr=0, mem_wdata=0, rdata0=rdata1=0, last-grant pointer=1.
REQ-024 Reset during ACC or DONE SHALL abort the transaction with no ack; the write SHALL not occur if reset is sampled at the ACC edge.
REQ-025 The first cycle after reset deassertion SHALL be IDLE, sampling requests.

Configuration
REQ-026 SHALL have macro DM_ARB_ROUND_ROBIN_EN.
REQ-027 With DM_ARB_ROUND_ROBIN_EN defined: on a conflict, grant the port not granted last; the pointer updates on every grant.
REQ-028 Without the macro: fixed priority; requester 0 always wins a conflict; the pointer logic is absent.

Structure
REQ-029 Package dm_arb_pkg SHALL hold DW/AW defaults and the FSM state typedef (IDLE, ACC, DONE).
REQ-030 The grant decision SHALL be a sub-module dm_arb_pick (inputs req0, req1, last; output winner), containing the macro-selected logic.

Verification
REQ-031 Single write: req0=1, we0=1, addr0=10'h2AA, wdata0=30'h3FFFFFFF at edge 0 -> mem_we=1 only in cycle 1 with mem_addr=10'h2AA; ack0 in cycle 2.
REQ-032 Read-back: req0 read of 10'h2AA after REQ-031 -> rdata0=30'h3FFFFFFF when ack0 is high; rdata1 unchanged.
REQ-033 Conflict, RR build: req0 and req1 both held high -> grants alternate 0,1,0,1 (first grant to 0 after reset); ack pulses 3 cycles apart.
REQ-034 Conflict, fixed build: req0 held high continuously with req1 high -> req1 is never acked while req0 is high; req1 is acked 3 cycles after req0 drops.
REQ-035 Reset in ACC: port-1 write of 30'h2FFFFFFF to 10'h248 with rst high at the ACC edge -> no ack, busy=0 next cycle, later read of 10'h248 returns the old value.
REQ-036 Idle: no requests for 20 cycles -> mem_we, ack0, ack1 and busy stay 0.
